// File: rtl/terminal_pkg.sv
// Shared types and constants for the terminal responder: FSM states, terminal
// selects, the "no function" code and the 7-segment digit-enable patterns.
package terminal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic       TERM_MATRIZ = 1'b0;
    localparam logic       TERM_LEDS   = 1'b1;
    localparam logic [2:0] CODE_NONE   = 3'b000;
    localparam logic [3:0] AC_ON       = 4'b1110;
    localparam logic [3:0] AC_OFF      = 4'b1111;

endpackage

// File: rtl/terminal_responder_hold_timer.sv
// Hold timer: START clears and arms the counter; EXPIRE is high during the
// last held cycle (count == HOLD_CYCLES-1), after which the timer disarms.
module hold_timer #(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    output logic EXPIRE
);
    localparam int                 CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_run;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (START) begin
            r_count <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            if (r_count == LAST) begin
                r_run <= 1'b0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign EXPIRE = r_run && (r_count == LAST);

endmodule

// File: rtl/terminal_responder.sv
// Two-user terminal responder: arbitrates requests, holds the granted code on
// its terminal for HOLD_CYCLES, then pulses DONE. TERMINAL_RESPONDER_RR_EN selects round-robin.
module terminal_responder
    import terminal_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ_VALID,
    input  logic [2:0] REQ_CODE0,
    input  logic [2:0] REQ_CODE1,
    input  logic [1:0] REQ_TERM,
    input  logic [2:0] REQ_AUT0,
    input  logic [2:0] REQ_AUT1,
    output logic [1:0] REQ_READY,
    output logic [2:0] FMATRIZ,
    output logic [2:0] FLEDS,
    output logic [2:0] F7SEG,
    output logic [3:0] AC_7SEG,
    output logic       DONE,
    output logic       DONE_USER,
    output logic       DONE_ERR
);
    state_t     r_state, w_state_next;
    logic       r_user, w_user_next;
    logic [2:0] r_code, w_code_next;
    logic       r_term, w_term_next;
    logic [2:0] r_aut, w_aut_next;

    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_accept_user;
    logic       w_expire;
    logic       w_start;
    logic       w_show_next;
    logic       w_done_next;

    logic [2:0] r_fmatriz, r_fleds, r_f7seg;
    logic [3:0] r_ac;
    logic       r_done, r_done_user, r_done_err;

`ifdef TERMINAL_RESPONDER_RR_EN
    logic r_ptr;

    // Pointer names the user that wins the next tie; it flips to the other user on every accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_accept_user;
        end
    end

    always_comb begin
        w_grant = REQ_VALID;
        if (REQ_VALID == 2'b11) begin
            w_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end
`else
    always_comb begin
        w_grant = REQ_VALID;
        if (REQ_VALID[0]) begin
            w_grant = 2'b01;
        end
    end
`endif

    assign REQ_READY     = (r_state == ST_IDLE && !RST) ? w_grant : 2'b00;
    assign w_accept      = |(REQ_VALID & REQ_READY);
    assign w_accept_user = REQ_READY[1];

    always_comb begin
        w_state_next = r_state;
        w_user_next  = r_user;
        w_code_next  = r_code;
        w_term_next  = r_term;
        w_aut_next   = r_aut;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_user_next  = w_accept_user;
                    w_code_next  = w_accept_user ? REQ_CODE1 : REQ_CODE0;
                    w_term_next  = REQ_TERM[w_accept_user];
                    w_aut_next   = w_accept_user ? REQ_AUT1 : REQ_AUT0;
                    w_state_next = (w_code_next == CODE_NONE) ? ST_DONE : ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_start     = (r_state == ST_IDLE) && (w_state_next == ST_SHOW);
    assign w_show_next = (w_state_next == ST_SHOW);
    assign w_done_next = (w_state_next == ST_DONE);

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .CLK   (CLK),
        .RST   (RST),
        .START (w_start),
        .EXPIRE(w_expire)
    );

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_user      <= 1'b0;
            r_code      <= CODE_NONE;
            r_term      <= TERM_MATRIZ;
            r_aut       <= 3'b000;
            r_fmatriz   <= 3'b000;
            r_fleds     <= 3'b000;
            r_f7seg     <= 3'b000;
            r_ac        <= AC_OFF;
            r_done      <= 1'b0;
            r_done_user <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_user      <= w_user_next;
            r_code      <= w_code_next;
            r_term      <= w_term_next;
            r_aut       <= w_aut_next;
            r_fmatriz   <= (w_show_next && w_term_next == TERM_MATRIZ) ? w_code_next : 3'b000;
            r_fleds     <= (w_show_next && w_term_next == TERM_LEDS) ? w_code_next : 3'b000;
            r_f7seg     <= w_show_next ? w_aut_next : 3'b000;
            r_ac        <= w_show_next ? AC_ON : AC_OFF;
            r_done      <= w_done_next;
            r_done_user <= w_done_next && w_user_next;
            r_done_err  <= w_done_next && (w_code_next == CODE_NONE);
        end
    end

    assign FMATRIZ   = r_fmatriz;
    assign FLEDS     = r_fleds;
    assign F7SEG     = r_f7seg;
    assign AC_7SEG   = r_ac;
    assign DONE      = r_done;
    assign DONE_USER = r_done_user;
    assign DONE_ERR  = r_done_err;

endmodule

// File: tb/tb_terminal_responder.sv
// Self-checking bench for terminal_responder with HOLD_CYCLES = 4: a timeline
// model of each accepted request is checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_terminal_responder;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [2:0] code0, code1, aut0, aut1;
    logic [1:0] term;
    logic [1:0] ready;
    logic [2:0] fm, fl, f7;
    logic [3:0] ac;
    logic       done, done_user, done_err;

    always #5 clk = ~clk;

    terminal_responder #(.HOLD_CYCLES(H)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid),
        .REQ_CODE0(code0), .REQ_CODE1(code1), .REQ_TERM(term),
        .REQ_AUT0(aut0), .REQ_AUT1(aut1), .REQ_READY(ready),
        .FMATRIZ(fm), .FLEDS(fl), .F7SEG(f7), .AC_7SEG(ac),
        .DONE(done), .DONE_USER(done_user), .DONE_ERR(done_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: one accepted request described by the cycle window it occupies.
    bit         m_init = 1'b0;
    bit         t_valid = 1'b0;
    int         t_start, t_end, t_done;
    bit         t_user, t_term;
    logic [2:0] t_code, t_aut;
    logic [1:0] m_acc = 2'b00;
    int         m_acc_cyc = 0;
`ifdef TERMINAL_RESPONDER_RR_EN
    bit         m_ptr = 1'b0;
`endif

    function automatic logic [1:0] pick(input logic [1:0] v);
`ifdef TERMINAL_RESPONDER_RR_EN
        if (v == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return v;
`else
        if (v[0]) return 2'b01;
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        logic       busy, show, dn;
        logic [1:0] er;
        int         c;
        c    = cyc;
        busy = t_valid && (c <= t_done);
        er   = (rst || busy) ? 2'b00 : pick(req_valid);
        if (m_init || rst) chk("req_ready", ready, er);
        if (m_init) begin
            show = t_valid && (t_code != 3'b000) && (c >= t_start) && (c <= t_end);
            dn   = t_valid && (c == t_done);
            chk("fmatriz", fm, (show && !t_term) ? t_code : 3'b000);
            chk("fleds", fl, (show && t_term) ? t_code : 3'b000);
            chk("f7seg", f7, show ? t_aut : 3'b000);
            chk("ac_7seg", ac, show ? 4'b1110 : 4'b1111);
            chk("done", done, dn);
            if (dn) begin
                chk("done_user", done_user, t_user);
                chk("done_err", done_err, t_code == 3'b000);
            end
        end
        m_acc = req_valid & er;
        if (rst) begin
            t_valid = 1'b0;
            m_init  = 1'b1;
`ifdef TERMINAL_RESPONDER_RR_EN
            m_ptr   = 1'b0;
`endif
        end else if (m_acc != 2'b00) begin
            t_valid   = 1'b1;
            t_user    = m_acc[1];
            t_code    = t_user ? code1 : code0;
            t_aut     = t_user ? aut1 : aut0;
            t_term    = term[t_user];
            t_start   = c + 1;
            t_end     = c + H;
            t_done    = (t_code == 3'b000) ? c + 1 : c + H + 1;
            m_acc_cyc = c;
`ifdef TERMINAL_RESPONDER_RR_EN
            m_ptr     = ~t_user;
`endif
        end
    end

    int g_user[8];
    int g_cyc[8];
    int g_cnt = 0;

    // Waits for n model accepts; the accepted requester drops VALID unless keep0 holds user 0.
    task automatic wait_grants(input int n, input bit keep0);
        int got;
        got = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(posedge clk); #1;
            if (m_acc != 2'b00) begin
                if (g_cnt < 8) begin
                    g_user[g_cnt] = m_acc[1] ? 1 : 0;
                    g_cyc[g_cnt]  = m_acc_cyc;
                    g_cnt++;
                end
                got++;
                if (!(m_acc[0] && keep0)) req_valid = req_valid & ~m_acc;
            end
        end
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_grants: got %0d grants, expected %0d", got, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        rst = 1'b1; req_valid = 2'b11; code0 = 3'b001; code1 = 3'b010;
        term = 2'b00; aut0 = 3'b001; aut1 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 2'b00);
        chk("rst_ac", ac, 4'b1111);
        chk("rst_fmatriz", fm, 3'b000);
        chk("rst_f7seg", f7, 3'b000);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;

        // Single request on the matrix
        @(posedge clk); #1;
        g_cnt = 0; code0 = 3'b101; term = 2'b00; aut0 = 3'b011; req_valid = 2'b01;
        wait_grants(1, 1'b0);
        chk("single_user", g_user[0], 0);
        for (int k = 0; k < H; k++) begin
            @(negedge clk);
            chk("single_fmatriz", fm, 3'b101);
            chk("single_f7seg", f7, 3'b011);
            chk("single_fleds", fl, 3'b000);
        end
        @(negedge clk);
        chk("single_done", done, 1'b1);
        chk("single_done_user", done_user, 1'b0);
        @(posedge clk); #1;

        // Error path: code 000 from user 1
        g_cnt = 0; code1 = 3'b000; aut1 = 3'b110; req_valid = 2'b10;
        wait_grants(1, 1'b0);
        @(negedge clk);
        chk("err_done", done, 1'b1);
        chk("err_flag", done_err, 1'b1);
        chk("err_user", done_user, 1'b1);
        chk("err_fmatriz", fm, 3'b000);
        chk("err_fleds", fl, 3'b000);
        @(posedge clk); #1;

        // Two simultaneous pairs
        code0 = 3'b010; code1 = 3'b111; term = 2'b10; aut0 = 3'b100; aut1 = 3'b101;
        for (int p = 0; p < 2; p++) begin
            g_cnt = 0; req_valid = 2'b11;
            wait_grants(2, 1'b0);
            chk("pair_first", g_user[0], 0);
            chk("pair_second", g_user[1], 1);
            chk("pair_spacing", g_cyc[1] - g_cyc[0], H + 2);
        end
        repeat (H + 2) @(posedge clk);
        #1;

        // User 0 keeps re-requesting against a waiting user 1
        g_cnt = 0; req_valid = 2'b11;
        wait_grants(2, 1'b1);
        req_valid[0] = 1'b0;
        chk("rereq_first", g_user[0], 0);
`ifdef TERMINAL_RESPONDER_RR_EN
        chk("rereq_second", g_user[1], 1);
`else
        chk("rereq_second", g_user[1], 0);
        wait_grants(1, 1'b0);
        chk("rereq_third", g_user[2], 1);
`endif
        repeat (H + 2) @(posedge clk);
        #1;

        // User 1 asks while user 0 is showing on the LEDs
        g_cnt = 0; code0 = 3'b011; term = 2'b01; aut0 = 3'b001;
        code1 = 3'b100; aut1 = 3'b010; req_valid = 2'b01;
        wait_grants(1, 1'b0);
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        wait_grants(1, 1'b0);
        chk("busy_user", g_user[1], 1);
        chk("busy_gap", g_cyc[1] - g_cyc[0], H + 2);
        repeat (H + 2) @(posedge clk);
        #1;

        // Reset in the middle of a show
        g_cnt = 0; code0 = 3'b110; term = 2'b01; aut0 = 3'b111; req_valid = 2'b01;
        wait_grants(1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_fleds", fl, 3'b000);
        chk("abort_f7seg", f7, 3'b000);
        chk("abort_ac", ac, 4'b1111);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/terminal_responder.md
# terminal_responder

Sequential responder at the terminal end of the two-user access-control path. It accepts function-code requests from user stations 0 and 1 over a valid/ready handshake and arbitrates between them. It presents the granted code to the matrix or LED terminal for a fixed hold time, then acknowledges completion with a one-cycle pulse. Its code outputs feed the existing matrix, LED and 7-segment decoders, replacing the combinational demux/mux routing with a timed, arbitrated path.

## Interface
- HOLD_CYCLES, default 50000000: cycles a granted code stays on its terminal (1 s at 50 MHz); legal range ≥ 1.
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  2  per-user request valid; bit 0 = user 0, bit 1 = user 1.
- REQ_CODE0 / REQ_CODE1  in  3 each  requested function code; 3'b000 = no function.
- REQ_TERM  in  2  per-user terminal select; 0 = matrix, 1 = LEDs.
- REQ_AUT0 / REQ_AUT1  in  3 each  requester authentication code, shown on 7-seg.
- REQ_READY  out  2  per-user accept strobe.
- FMATRIZ  out  3  code to matrix decoder.
- FLEDS  out  3  code to LED decoder.
- F7SEG  out  3  authentication code of the active user.
- AC_7SEG  out  4  digit enable, active-low; 4'b1110 while showing, 4'b1111 otherwise.
- DONE  out  1  one-cycle completion pulse.
- DONE_USER  out  1  user index qualified by DONE.
- DONE_ERR  out  1  qualified by DONE; 1 if the request carried code 3'b000.

## Operation
- States: IDLE, SHOW, DONE.
- IDLE:
  - REQ_READY is combinational and one-hot: the bit of the granted user, or 0 when no valid.
  - A request is accepted in a cycle where REQ_VALID[i] & REQ_READY[i].
  - On accept, the code, terminal and aut are latched, and the state moves to SHOW, or to DONE directly if the code = 3'b000.
- SHOW:
  - The latched code drives FMATRIZ or FLEDS per the latched terminal; the other terminal output is 0.
  - F7SEG = latched aut; AC_7SEG = 4'b1110.
  - The hold counter counts up from 0; at HOLD_CYCLES-1 the state moves to DONE.
- DONE:
  - FMATRIZ, FLEDS and F7SEG are 0 and AC_7SEG = 4'b1111.
  - DONE = 1 with DONE_USER and DONE_ERR valid; next state is IDLE.
- Requesters hold VALID and their payload stable until READY. Deasserting VALID before READY withdraws the request without error.
- REQ_READY is 0 in SHOW and DONE. Requests arriving there wait.
- Reset: state IDLE, all outputs 0 except AC_7SEG = 4'b1111, arbitration pointer = user 0, counter cleared. RST asserted mid-SHOW aborts the display at the next edge with no DONE pulse.
- Counter width is $clog2(HOLD_CYCLES+1). Wrap-around cannot occur because the counter is cleared on every entry to SHOW.

## Timing
- Accept at edge T: outputs show the code from cycle T+1 for exactly HOLD_CYCLES cycles. DONE is high in cycle T+1+HOLD_CYCLES.
- Earliest next READY is cycle T+2+HOLD_CYCLES (one IDLE cycle), so back-to-back grants are spaced HOLD_CYCLES+2 cycles apart.
- A code-000 request accepted at T: DONE with DONE_ERR = 1 in cycle T+1, and terminal outputs stay 0.
- Outputs are registered except REQ_READY.

## Configuration
- TERMINAL_RESPONDER_RR_EN defined:
  - Round-robin arbitration when both users are valid in IDLE.
  - The pointer moves to the other user after each accept.
- TERMINAL_RESPONDER_RR_EN undefined:
  - Fixed priority: user 0 always wins a simultaneous request.
  - The pointer register is not built.

## Structure
- Package terminal_pkg holds:
  - state enum (IDLE/SHOW/DONE);
  - TERM_MATRIZ = 0, TERM_LEDS = 1;
  - CODE_NONE = 3'b000;
  - AC_ON = 4'b1110, AC_OFF = 4'b1111.
- Sub-module hold_timer (parameter HOLD_CYCLES; inputs CLK, RST, START; output EXPIRE) contains the counter. The top holds the FSM, arbiter and payload registers.

## Test plan
- Reset: RST high for 2 cycles while REQ_VALID = 2'b11. After reset, all outputs are 0, AC_7SEG = 4'b1111, and REQ_READY = 0 while RST is held.
- Single request with HOLD_CYCLES = 4: user 0, code 3'b101, terminal 0, aut 3'b011, accepted at T.
  - FMATRIZ = 3'b101, F7SEG = 3'b011 and FLEDS = 0 for cycles T+1..T+4.
  - DONE = 1 with DONE_USER = 0 at T+5.
- Simultaneous requests (both valid, RR_EN defined): order is user 0 then user 1. A second simultaneous pair is granted user 0 then user 1 again. With RR_EN undefined and user 0 re-requesting, user 0 wins every time.
- Error path: user 1 sends code 3'b000. The next cycle has DONE = 1, DONE_ERR = 1, DONE_USER = 1, and FMATRIZ/FLEDS stay 0.
- Busy blocking: user 1 asserts VALID during user 0's SHOW. REQ_READY[1] stays 0 until the IDLE cycle after DONE, then pulses.
- Mid-operation reset: RST asserted at cycle T+2 of a HOLD_CYCLES = 4 show. Outputs are 0 at T+3 and no DONE pulse is ever emitted.
